uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 17 +
 rtl/uart_tx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Push-side handshake bundle for the UART transmitter FIFO.
// Revision : 1.0
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 data_valid;
    logic [DATA_BITS-1:0] data;
    logic                 ready;

    modport master (output data_valid, output data, input ready);
    modport slave  (input data_valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmitter fed by a small FIFO; back-to-back frames.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    uart_tx_fifo_if.slave               s_push,
    output logic                        serial_op,
    output logic                        active,
    output logic                        done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);

    localparam logic [BAUD_W-1:0] C_BIT_END    = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] C_STOP_END   = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [2:0]        C_LAST_BIT   = 3'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  C_FULL       = CNT_W'(FIFO_DEPTH);
    localparam bit                C_HAS_PARITY = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [BAUD_W-1:0]    r_baud;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_serial;
    logic                 r_active;
    logic                 r_done;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_stop_end;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    // ready depends only on the registered count, never on data_valid
    assign s_push.ready = (r_count != C_FULL);
    assign w_push       = s_push.data_valid && s_push.ready;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_par   = (PARITY == 1) ? ~(^w_head) : (^w_head);
    assign w_bit_end    = (r_baud == C_BIT_END);
    assign w_stop_end   = (r_baud == C_STOP_END);
    assign w_pop        = (r_count != '0) &&
                          ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_end));

    assign serial_op  = r_serial;
    assign active     = r_active;
    assign done       = r_done;
    assign fifo_count = r_count;

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_push.data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_serial  <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud    <= '0;
                    r_bit_idx <= '0;
                    r_serial  <= 1'b1;
                    r_active  <= 1'b0;
                    if (w_pop) begin
                        r_shift   <= w_head;
                        r_par_bit <= w_head_par;
                        r_serial  <= 1'b0;
                        r_active  <= 1'b1;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud   <= '0;
                        r_serial <= r_shift[0];
                        r_state  <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == C_LAST_BIT) begin
                            r_bit_idx <= '0;
                            if (C_HAS_PARITY) begin
                                r_serial <= r_par_bit;
                                r_state  <= S_PARITY;
                            end else begin
                                r_serial <= 1'b1;
                                r_state  <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_serial  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud   <= '0;
                        r_serial <= 1'b1;
                        r_state  <= S_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_stop_end) begin
                        r_baud <= '0;
                        r_done <= 1'b1;
                        // A waiting entry starts its start bit while done pulses
                        if (w_pop) begin
                            r_shift   <= w_head;
                            r_par_bit <= w_head_par;
                            r_serial  <= 1'b0;
                            r_state   <= S_START;
                        end else begin
                            r_serial <= 1'b1;
                            r_active <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_baud    <= '0;
                    r_bit_idx <= '0;
                    r_serial  <= 1'b1;
                    r_active  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Self-checking bench: line receiver, FIFO occupancy model, vectors.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB     = 4;
    localparam int DEPTH   = 4;
    localparam int FRAME_A = (1 + 8 + 1 + 1) * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8)) a_if ();
    uart_tx_fifo_if #(.DATA_BITS(7)) b_if ();

    logic       a_ser, a_act, a_done;
    logic [2:0] a_cnt;
    logic       b_ser, b_act, b_done;
    logic [2:0] b_cnt;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                   .FIFO_DEPTH(DEPTH)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .s_push(a_if),
        .serial_op(a_ser), .active(a_act), .done(a_done), .fifo_count(a_cnt));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
                   .FIFO_DEPTH(DEPTH)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .s_push(b_if),
        .serial_op(b_ser), .active(b_act), .done(b_done), .fifo_count(b_cnt));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] data; logic par; int start; } frame_t;
    typedef struct { int id; logic [7:0] data; logic par; } vec_t;

    frame_t     rx_a[$];
    frame_t     rx_b[$];
    logic [7:0] exp_a[$];
    int         m_cnt, m_cyc, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic mon_line(input int id); return (id == 0) ? a_ser  : b_ser;  endfunction
    function automatic logic mon_act (input int id); return (id == 0) ? a_act  : b_act;  endfunction
    function automatic logic mon_done(input int id); return (id == 0) ? a_done : b_done; endfunction

    // Receiver: captures each frame from its start bit, checks its shape and timing.
    task automatic monitor(input int id, input int dbits, input int par, input int stops);
        int         nslot, frame, start_c;
        bit         pend, aborted, ok_ad, ok_fmt;
        logic       smp [512];
        logic [7:0] d;
        logic       v;
        frame_t     f;
        nslot = 1 + dbits + ((par != 0) ? 1 : 0) + stops;
        frame = nslot * CPB;
        pend  = 0;
        forever begin
            if (!pend) @(negedge clk);
            pend = 0;
            if (rst_n === 1'b1 && mon_line(id) === 1'b0) begin
                start_c = cyc;
                aborted = 0;
                ok_ad   = 1;
                for (int k = 0; k < frame; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst_n !== 1'b1) aborted = 1;
                    smp[k] = mon_line(id);
                    if (mon_act(id) !== 1'b1 || (k > 0 && mon_done(id) !== 1'b0)) ok_ad = 0;
                end
                @(negedge clk);
                if (rst_n !== 1'b1) aborted = 1;
                if (!aborted) begin
                    ok_fmt = 1;
                    d = '0;
                    v = 1'b0;
                    for (int s = 0; s < nslot; s++) begin
                        for (int j = 1; j < CPB; j++)
                            if (smp[s*CPB+j] !== smp[s*CPB]) ok_fmt = 0;
                        if (s == 0 && smp[0] !== 1'b0) ok_fmt = 0;
                        if (s >= nslot - stops && smp[s*CPB] !== 1'b1) ok_fmt = 0;
                        if (s >= 1 && s <= dbits) d[s-1] = smp[s*CPB];
                    end
                    if (par != 0) v = smp[(1 + dbits) * CPB];
                    chk($sformatf("frame_shape_%0d", id), ok_fmt, 1);
                    chk($sformatf("active_high_done_low_%0d", id), ok_ad, 1);
                    chk($sformatf("done_pulse_%0d", id), mon_done(id), 1);
                    pend = (mon_line(id) === 1'b0);
                    chk($sformatf("active_after_frame_%0d", id), mon_act(id), pend);
                    f.data  = d;
                    f.par   = v;
                    f.start = start_c;
                    if (id == 0) rx_a.push_back(f); else rx_b.push_back(f);
                end
            end
        end
    endtask

    // One clock of stimulus; DUT A occupancy is predicted from frame timing rules.
    task automatic step(input bit va, input logic [7:0] da, input bit vb, input logic [6:0] db);
        bit acc, pop;
        a_if.data_valid = va;
        a_if.data       = da;
        b_if.data_valid = vb;
        b_if.data       = db;
        chk("a_fifo_count", a_cnt, m_cnt);
        chk("a_ready", a_if.ready, (m_cnt != DEPTH));
        acc = va && (m_cnt != DEPTH);
        pop = (m_cnt > 0) && (m_cyc >= m_last);
        if (acc) exp_a.push_back(da);
        if (pop) m_last = m_cyc + FRAME_A;
        m_cnt = m_cnt + int'(acc) - int'(pop);
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n  = 1'b1;
        m_cnt  = 0;
        m_cyc  = 0;
        m_last = -1;
        exp_a.delete();
    endtask

    task automatic get_frame(input int id, output frame_t f, output bit got);
        got = 0;
        f   = '{default: 0};
        for (int i = 0; i < 600 && !got; i++) begin
            if (id == 0 && rx_a.size() > 0) begin
                f = rx_a.pop_front(); got = 1;
            end else if (id == 1 && rx_b.size() > 0) begin
                f = rx_b.pop_front(); got = 1;
            end else begin
                step(0, 8'h00, 0, 7'h00);
            end
        end
        chk($sformatf("frame_arrived_%0d", id), got, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt [8];
        frame_t     f;
        bit         got;
        logic [7:0] burst [6];
        logic [7:0] ed;
        int         prev_start, bad, s0, guard;

        vt[0] = '{0, 8'hA5, 1'b0};
        vt[1] = '{0, 8'h00, 1'b0};
        vt[2] = '{0, 8'hFF, 1'b0};
        vt[3] = '{0, 8'h01, 1'b1};
        vt[4] = '{0, 8'h3C, 1'b0};
        vt[5] = '{1, 8'h41, 1'b1};
        vt[6] = '{1, 8'h7F, 1'b0};
        vt[7] = '{1, 8'h00, 1'b1};

        a_if.data_valid = 1'b0; a_if.data = '0;
        b_if.data_valid = 1'b0; b_if.data = '0;
        fork
            monitor(0, 8, 2, 1);
            monitor(1, 7, 1, 2);
        join_none

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_serial", a_ser, 1);
        chk("rst_a_active", a_act, 0);
        chk("rst_a_done",   a_done, 0);
        chk("rst_a_ready",  a_if.ready, 1);
        chk("rst_a_count",  a_cnt, 0);
        chk("rst_b_serial", b_ser, 1);
        chk("rst_b_ready",  b_if.ready, 1);
        chk("rst_b_count",  b_cnt, 0);
        release_reset();

        // Vector table; first push lands on the first edge after release
        for (int i = 0; i < 8; i++) begin
            if (vt[i].id == 0) step(1, vt[i].data, 0, 7'h00);
            else               step(0, 8'h00, 1, vt[i].data[6:0]);
            get_frame(vt[i].id, f, got);
            if (got) begin
                chk($sformatf("vec%0d_data", i), f.data, vt[i].data);
                chk($sformatf("vec%0d_parity", i), f.par, vt[i].par);
            end
            if (vt[i].id == 0 && exp_a.size() > 0) void'(exp_a.pop_front());
        end

        // Six consecutive pushes into a depth-4 FIFO
        for (int i = 0; i < 6; i++) burst[i] = 8'(8'h10 + 8'(i) * 8'h11);
        for (int i = 0; i < 6; i++) step(1, burst[i], 0, 7'h00);
        chk("burst_ready_low", a_if.ready, 0);
        chk("burst_count_full", a_cnt, 4);

        // Push attempt while full on the last stop cycle of the running frame
        guard = 0;
        while (m_cyc != m_last && guard < 100) begin
            step(0, 8'h00, 0, 7'h00);
            guard++;
        end
        chk("full_push_ready", a_if.ready, 0);
        step(1, 8'hEE, 0, 7'h00);
        chk("pop_on_full_push_count", a_cnt, 3);

        prev_start = 0;
        for (int k = 0; k < 5; k++) begin
            get_frame(0, f, got);
            if (got) begin
                chk($sformatf("burst%0d_data", k), f.data, burst[k]);
                if (k > 0) chk($sformatf("burst%0d_gap", k), f.start - prev_start, FRAME_A);
                prev_start = f.start;
            end
            if (exp_a.size() > 0) void'(exp_a.pop_front());
        end

        // Reset during data bit 3 with two entries queued
        step(1, 8'hC3, 0, 7'h00);
        step(1, 8'h5A, 0, 7'h00);
        step(1, 8'h96, 0, 7'h00);
        s0 = m_last - FRAME_A + 1;
        while (m_cyc < s0 + 17) step(0, 8'h00, 0, 7'h00);
        chk("pre_reset_count", a_cnt, 2);
        chk("pre_reset_bit3", a_ser, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_serial", a_ser, 1);
        chk("async_rst_count", a_cnt, 0);
        chk("async_rst_active", a_act, 0);
        chk("async_rst_ready", a_if.ready, 1);
        repeat (2) @(negedge clk);
        release_reset();
        bad = 0;
        repeat (150) begin
            if (a_ser !== 1'b1 || a_act !== 1'b0) bad++;
            step(0, 8'h00, 0, 7'h00);
        end
        chk("no_frame_after_reset", bad, 0);
        chk("no_rx_after_reset", rx_a.size(), 0);

        // Random pushes: heavy traffic then sparse traffic
        for (int i = 0; i < 700; i++) begin
            bit v;
            v = ($urandom_range(0, 99) < ((i < 350) ? 70 : 3));
            step(v, 8'($urandom), 0, 7'h00);
        end
        guard = 0;
        while (exp_a.size() > 0 && guard < 40) begin
            get_frame(0, f, got);
            guard++;
            if (!got) break;
            ed = exp_a.pop_front();
            chk("rand_data", f.data, ed);
            chk("rand_parity", f.par, ($countones(ed) % 2));
        end
        chk("rand_all_sent", exp_a.size(), 0);
        chk("b_no_extra_frames", rx_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
